// File: rtl/lcd_ctrl_pkg.sv
// Shared constants for the HD44780 LCD sequencer: state encoding, init ROM,
// pin positions in the IO word and the slow-command opcodes.
package lcd_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_PWR_WAIT = 3'd0;
  localparam state_t ST_LOAD     = 3'd1;
  localparam state_t ST_SETUP    = 3'd2;
  localparam state_t ST_PULSE    = 3'd3;
  localparam state_t ST_HOLD     = 3'd4;
  localparam state_t ST_WAIT     = 3'd5;
  localparam state_t ST_IDLE     = 3'd6;

  localparam int INIT_LEN = 6;
  // Entry 0 sits in the low byte: function set x3, display on, clear, entry mode.
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM =
    {8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38};

  localparam int LCD_ON = 31;
  localparam int LCD_EN = 10;
  localparam int LCD_RS = 9;
  localparam int LCD_RW = 8;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == CMD_CLEAR || data == CMD_HOME);
  endfunction

endpackage

// File: rtl/lcd_ctrl_timer.sv
// Loadable saturating down-counter; o_done marks the last cycle of a timed state.
module lcd_ctrl_timer #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: no reset here; the parent holds i_load high through reset, which
  // leaves the count defined without a second reset path into the datapath.
  always_ff @(posedge i_clk) begin
    if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // A load value of 0 or 1 both give a one-cycle state.
  assign o_done = (r_cnt <= CNT_W'(1));

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 sequencer: autonomous power-up init, then one command/data byte per
// valid/ready handshake with full setup/EN/hold/busy-wait timing.
module lcd_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int INIT_WAIT_CYC = 750000,
  parameter int SETUP_CYC     = 2,
  parameter int PULSE_CYC     = 24,
  parameter int HOLD_CYC      = 2,
  parameter int CMD_WAIT_CYC  = 2000,
  parameter int CLR_WAIT_CYC  = 82000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_vld,
  output logic        o_req_rdy,
  input  logic        i_req_rs,
  input  logic [7:0]  i_req_data,
  output logic        o_busy,
  output logic        o_init_done,
  output logic [31:0] o_io_lcd
);

  localparam int MAX_CYC = max_of(max_of(max_of(INIT_WAIT_CYC, SETUP_CYC),
                                         max_of(PULSE_CYC, HOLD_CYC)),
                                  max_of(CMD_WAIT_CYC, CLR_WAIT_CYC));
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  state_t           r_state;
  state_t           w_next;
  logic             r_run;
  logic             r_init_done;
  logic [2:0]       r_idx;
  logic             r_rs;
  logic [7:0]       r_data;
  logic             w_done;
  logic             w_load;
  logic             w_accept;
  logic [CNT_W-1:0] w_load_val;

  assign w_accept = (r_state == ST_IDLE) && i_req_vld;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_PWR_WAIT: if (w_done) w_next = ST_LOAD;
      ST_LOAD:     w_next = ST_SETUP;
      ST_SETUP:    if (w_done) w_next = ST_PULSE;
      ST_PULSE:    if (w_done) w_next = ST_HOLD;
      ST_HOLD:     if (w_done) w_next = ST_WAIT;
      ST_WAIT: begin
        if (w_done) begin
          w_next = (!r_init_done && r_idx != 3'(INIT_LEN - 1)) ? ST_LOAD : ST_IDLE;
        end
      end
      ST_IDLE:     if (i_req_vld) w_next = ST_SETUP;
      default:     w_next = ST_PWR_WAIT;
    endcase
    // The release cycle only arms the power-up delay.
    if (!r_run) w_next = ST_PWR_WAIT;
  end

  // The counter reloads on every state entry with the length of the new state.
  always_comb begin
    w_load     = !i_reset || !r_run || (w_next != r_state);
    w_load_val = CNT_W'(1);
    if (!i_reset || !r_run) begin
      w_load_val = CNT_W'(INIT_WAIT_CYC);
    end else begin
      case (w_next)
        ST_PWR_WAIT: w_load_val = CNT_W'(INIT_WAIT_CYC);
        ST_SETUP:    w_load_val = CNT_W'(SETUP_CYC);
        ST_PULSE:    w_load_val = CNT_W'(PULSE_CYC);
        ST_HOLD:     w_load_val = CNT_W'(HOLD_CYC);
        ST_WAIT:     w_load_val = is_slow_cmd(r_rs, r_data) ? CNT_W'(CLR_WAIT_CYC)
                                                             : CNT_W'(CMD_WAIT_CYC);
        default:     w_load_val = CNT_W'(1);
      endcase
    end
  end

  lcd_ctrl_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clk      (i_clk),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= ST_PWR_WAIT;
      r_run       <= 1'b0;
      r_init_done <= 1'b0;
      r_idx       <= '0;
      r_rs        <= 1'b0;
      r_data      <= '0;
    end else begin
      r_run   <= 1'b1;
      r_state <= w_next;
      if (r_state == ST_LOAD) begin
        r_rs   <= 1'b0;
        r_data <= INIT_ROM[r_idx];
      end
      if (w_accept) begin
        r_rs   <= i_req_rs;
        r_data <= i_req_data;
      end
      if (r_state == ST_WAIT && w_done && !r_init_done) begin
        if (r_idx == 3'(INIT_LEN - 1)) r_init_done <= 1'b1;
        else                           r_idx       <= r_idx + 3'd1;
      end
    end
  end

  assign o_req_rdy   = (r_state == ST_IDLE);
  assign o_busy      = r_run && (r_state != ST_IDLE);
  assign o_init_done = r_init_done;

  always_comb begin
    o_io_lcd         = '0;
    o_io_lcd[LCD_ON] = r_run;
    o_io_lcd[LCD_EN] = (r_state == ST_PULSE);
    o_io_lcd[LCD_RS] = r_rs;
    o_io_lcd[LCD_RW] = 1'b0;
    o_io_lcd[7:0]    = r_data;
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: scoreboard of expected EN-pulse bytes,
// a table of single requests and hand-written handshake/reset sequences.
module tb_lcd_ctrl;

  localparam int INIT_WAIT = 20;
  localparam int SETUP     = 2;
  localparam int PULSE     = 4;
  localparam int HOLD      = 2;
  localparam int CMD_WAIT  = 8;
  localparam int CLR_WAIT  = 30;
  localparam int LAT_CMD   = SETUP + PULSE + HOLD + CMD_WAIT + 1;
  localparam int LAT_CLR   = SETUP + PULSE + HOLD + CLR_WAIT + 1;
  localparam int EN_LAT    = SETUP + 1;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_byte_t;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         exp_lat;
  } vec_t;

  logic        i_clk;
  logic        i_reset;
  logic        i_req_vld;
  logic        o_req_rdy;
  logic        i_req_rs;
  logic [7:0]  i_req_data;
  logic        o_busy;
  logic        o_init_done;
  logic [31:0] o_io_lcd;

  lcd_ctrl #(
    .INIT_WAIT_CYC (INIT_WAIT),
    .SETUP_CYC     (SETUP),
    .PULSE_CYC     (PULSE),
    .HOLD_CYC      (HOLD),
    .CMD_WAIT_CYC  (CMD_WAIT),
    .CLR_WAIT_CYC  (CLR_WAIT)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_req_vld   (i_req_vld),
    .o_req_rdy   (o_req_rdy),
    .i_req_rs    (i_req_rs),
    .i_req_data  (i_req_data),
    .o_busy      (o_busy),
    .o_init_done (o_init_done),
    .o_io_lcd    (o_io_lcd)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          pulses = 0;
  int          rise_cyc = 0;
  logic        prev_en = 1'b0;
  logic        cur_en;
  logic        init_phase = 1'b0;
  logic        have_prev = 1'b0;
  lcd_byte_t   prev_b;
  lcd_byte_t   pop_b;
  lcd_byte_t   sb_q[$];
  lcd_byte_t   init_rom[6];
  int          init_total;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int wait_of(input lcd_byte_t b);
    return (!b.rs && (b.data == 8'h01 || b.data == 8'h02)) ? CLR_WAIT : CMD_WAIT;
  endfunction

  // Scoreboard consumer: every EN rise must carry the oldest expected byte.
  always @(negedge i_clk) begin
    cur_en = o_io_lcd[10];
    if (cur_en && !prev_en) begin
      pulses++;
      if (sb_q.size() == 0) begin
        check("pulse_with_empty_queue", sb_q.size(), 1);
      end else begin
        pop_b = sb_q.pop_front();
        check("pulse_byte", {22'd0, o_io_lcd[9:0]}, {22'd0, pop_b.rs, 1'b0, pop_b.data});
        if (init_phase && have_prev)
          check("init_pulse_spacing", cyc - rise_cyc, PULSE + HOLD + wait_of(prev_b) + 1 + SETUP);
        prev_b    = pop_b;
        have_prev = 1'b1;
      end
      rise_cyc = cyc;
    end
    if (!cur_en && prev_en && i_reset)
      check("pulse_width", cyc - rise_cyc, PULSE);
    prev_en = cur_en;
  end

  task automatic reset_and_init();
    int c;
    int bad;
    int p0;
    i_reset   = 1'b0;
    i_req_vld = 1'b0;
    sb_q.delete();
    repeat (5) @(negedge i_clk);
    check("rst_io_lcd", o_io_lcd, 32'h0);
    check("rst_rdy", {31'd0, o_req_rdy}, 0);
    check("rst_busy", {31'd0, o_busy}, 0);
    check("rst_init_done", {31'd0, o_init_done}, 0);
    foreach (init_rom[i]) sb_q.push_back(init_rom[i]);
    have_prev  = 1'b0;
    init_phase = 1'b1;
    p0         = pulses;
    i_reset    = 1'b1;
    @(negedge i_clk);
    check("on_at_cycle0", {31'd0, o_io_lcd[31]}, 1);
    check("busy_at_cycle0", {31'd0, o_busy}, 1);
    c   = 0;
    bad = 0;
    while (!o_init_done && c < 2000) begin
      if (!o_busy || o_req_rdy || !o_io_lcd[31]) bad++;
      @(negedge i_clk);
      c++;
    end
    check("init_done_cycle", c, init_total);
    check("busy_rdy_during_init", bad, 0);
    check("init_pulse_count", pulses - p0, 6);
    check("init_queue_drained", sb_q.size(), 0);
    check("rdy_after_init", {31'd0, o_req_rdy}, 1);
    check("busy_after_init", {31'd0, o_busy}, 0);
    init_phase = 1'b0;
  endtask

  task automatic wait_rdy(input string name);
    int w;
    w = 0;
    while (!o_req_rdy && w < 200) begin
      @(negedge i_clk);
      w++;
    end
    check(name, {31'd0, o_req_rdy}, 1);
  endtask

  task automatic send(input logic rs, input logic [7:0] d, input int exp_lat, input string tag);
    int   k;
    int   en_k;
    logic stable;
    wait_rdy({tag, "_rdy_before"});
    i_req_vld  = 1'b1;
    i_req_rs   = rs;
    i_req_data = d;
    sb_q.push_back({rs, d});
    @(negedge i_clk);
    // Scramble inputs after the accept edge; the latched byte must not follow.
    i_req_vld  = 1'b0;
    i_req_rs   = ~rs;
    i_req_data = ~d;
    k      = 1;
    en_k   = -1;
    stable = 1'b1;
    while (!o_req_rdy && k < 400) begin
      if (o_io_lcd[10] && en_k < 0) en_k = k;
      if (k >= EN_LAT && k < EN_LAT + PULSE + HOLD && o_io_lcd[9:0] !== {rs, 1'b0, d})
        stable = 1'b0;
      @(negedge i_clk);
      k++;
    end
    check({tag, "_rdy_latency"}, k, exp_lat);
    check({tag, "_en_latency"}, en_k, EN_LAT);
    check({tag, "_pins_stable"}, {31'd0, stable}, 1);
  endtask

  initial begin
    vec_t      vecs[6];
    lcd_byte_t hold_bytes[3];
    int        p0;
    int        w;
    logic      saw_en;

    init_rom[0] = '{rs: 1'b0, data: 8'h38};
    init_rom[1] = '{rs: 1'b0, data: 8'h38};
    init_rom[2] = '{rs: 1'b0, data: 8'h38};
    init_rom[3] = '{rs: 1'b0, data: 8'h0C};
    init_rom[4] = '{rs: 1'b0, data: 8'h01};
    init_rom[5] = '{rs: 1'b0, data: 8'h06};
    init_total = INIT_WAIT;
    foreach (init_rom[i]) init_total += 1 + SETUP + PULSE + HOLD + wait_of(init_rom[i]);

    vecs[0] = '{rs: 1'b1, data: 8'h41, exp_lat: LAT_CMD};
    vecs[1] = '{rs: 1'b0, data: 8'h01, exp_lat: LAT_CLR};
    vecs[2] = '{rs: 1'b0, data: 8'h80, exp_lat: LAT_CMD};
    vecs[3] = '{rs: 1'b0, data: 8'h02, exp_lat: LAT_CLR};
    vecs[4] = '{rs: 1'b1, data: 8'h01, exp_lat: LAT_CMD};
    vecs[5] = '{rs: 1'b0, data: 8'h03, exp_lat: LAT_CMD};

    hold_bytes[0] = '{rs: 1'b1, data: 8'h48};
    hold_bytes[1] = '{rs: 1'b0, data: 8'h01};
    hold_bytes[2] = '{rs: 1'b1, data: 8'h49};

    i_reset    = 1'b0;
    i_req_vld  = 1'b0;
    i_req_rs   = 1'b0;
    i_req_data = 8'h00;

    reset_and_init();

    foreach (vecs[i]) send(vecs[i].rs, vecs[i].data, vecs[i].exp_lat, $sformatf("vec%0d", i));

    // Valid held high across three transactions with noise on the data lines.
    wait_rdy("hold_rdy_before");
    p0        = pulses;
    i_req_vld = 1'b1;
    for (int t = 0; t < 3; t++) begin
      i_req_rs   = hold_bytes[t].rs;
      i_req_data = hold_bytes[t].data;
      sb_q.push_back(hold_bytes[t]);
      @(negedge i_clk);
      w = 0;
      while (!o_req_rdy && w < 200) begin
        i_req_rs   = 1'($urandom);
        i_req_data = 8'($urandom);
        @(negedge i_clk);
        w++;
      end
    end
    i_req_vld = 1'b0;
    check("hold_vld_accepts", pulses - p0, 3);
    check("hold_vld_queue_drained", sb_q.size(), 0);

    // Reset asserted while EN is high.
    wait_rdy("midrst_rdy_before");
    i_req_vld  = 1'b1;
    i_req_rs   = 1'b1;
    i_req_data = 8'h55;
    sb_q.push_back('{rs: 1'b1, data: 8'h55});
    @(negedge i_clk);
    i_req_vld = 1'b0;
    w         = 0;
    while (!o_io_lcd[10] && w < 50) begin
      @(negedge i_clk);
      w++;
    end
    saw_en  = o_io_lcd[10];
    check("midrst_en_reached", {31'd0, saw_en}, 1);
    i_reset = 1'b0;
    @(negedge i_clk);
    check("midrst_io_lcd_zero", o_io_lcd, 32'h0);
    check("midrst_busy", {31'd0, o_busy}, 0);
    check("midrst_init_done", {31'd0, o_init_done}, 0);

    reset_and_init();
    send(1'b1, 8'h5A, LAT_CMD, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
